// File: rtl/ctrl_pipe_decoder.sv
// Pipelined MIPS main-control decoder: ID decode, load-use hazard detection, ID/EX, EX/MEM and MEM/WB control registers.
// Optional feature macro: DECODE_BNE_EN (op 000101 decodes as bne; otherwise it is illegal).
module ctrl_pipe_decoder #(
    parameter int ALUOP_W = 3,
    parameter int REG_W   = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        instr_i,
    input  logic               instr_valid_i,
    input  logic               flush_i,
    output logic               id_jump_o,
    output logic               id_jr_o,
    output logic               illegal_o,
    output logic               stall_o,
    output logic [ALUOP_W-1:0] ex_aluop_o,
    output logic               ex_alusrc_o,
    output logic               ex_memread_o,
    output logic [REG_W-1:0]   ex_dst_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               mem_branch_o,
    output logic [1:0]         mem_btype_o,
    output logic [REG_W-1:0]   mem_dst_o,
    output logic               wb_regwrite_o,
    output logic [1:0]         wb_memtoreg_o,
    output logic [REG_W-1:0]   wb_dst_o
);

    typedef struct packed {
        logic [ALUOP_W-1:0] aluop;
        logic               alusrc;
        logic               memread;
        logic               memwrite;
        logic               branch;
        logic [1:0]         btype;
        logic               regwrite;
        logic [1:0]         memtoreg;
        logic [REG_W-1:0]   dst;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [5:0] funct;

    assign op    = instr_i[31:26];
    assign rs    = instr_i[25:21];
    assign rt    = instr_i[20:16];
    assign rd    = instr_i[15:11];
    assign funct = instr_i[5:0];

    ctrl_t dec_word;
    logic  dec_jump;
    logic  dec_jr;
    logic  dec_illegal;
    logic  dec_kill;
    logic  dec_uses_rt;

    // j, jr and illegal opcodes decode to a zero word and are also forced into a bubble.
    always_comb begin
        dec_word    = '0;
        dec_jump    = 1'b0;
        dec_jr      = 1'b0;
        dec_illegal = 1'b0;
        dec_kill    = 1'b0;
        dec_uses_rt = 1'b0;
        case (op)
            OP_RTYPE: begin
                if (funct == FN_JR) begin
                    dec_jr   = 1'b1;
                    dec_kill = 1'b1;
                end else begin
                    dec_word.aluop    = ALUOP_W'(3'b010);
                    dec_word.dst      = REG_W'(rd);
                    dec_word.regwrite = 1'b1;
                    dec_uses_rt       = 1'b1;
                end
            end
            OP_ADDI: begin
                dec_word.aluop    = ALUOP_W'(3'b000);
                dec_word.alusrc   = 1'b1;
                dec_word.dst      = REG_W'(rt);
                dec_word.regwrite = 1'b1;
            end
            OP_SLTI: begin
                dec_word.aluop    = ALUOP_W'(3'b011);
                dec_word.alusrc   = 1'b1;
                dec_word.dst      = REG_W'(rt);
                dec_word.regwrite = 1'b1;
            end
            OP_LW: begin
                dec_word.aluop    = ALUOP_W'(3'b000);
                dec_word.alusrc   = 1'b1;
                dec_word.memread  = 1'b1;
                dec_word.dst      = REG_W'(rt);
                dec_word.regwrite = 1'b1;
                dec_word.memtoreg = 2'b01;
            end
            OP_SW: begin
                dec_word.aluop    = ALUOP_W'(3'b000);
                dec_word.alusrc   = 1'b1;
                dec_word.memwrite = 1'b1;
                dec_uses_rt       = 1'b1;
            end
            OP_BEQ: begin
                dec_word.aluop  = ALUOP_W'(3'b001);
                dec_word.branch = 1'b1;
                dec_word.btype  = 2'b00;
                dec_uses_rt     = 1'b1;
            end
            OP_BNE: begin
`ifdef DECODE_BNE_EN
                dec_word.aluop  = ALUOP_W'(3'b001);
                dec_word.branch = 1'b1;
                dec_word.btype  = 2'b01;
                dec_uses_rt     = 1'b1;
`else
                dec_illegal = 1'b1;
                dec_kill    = 1'b1;
`endif
            end
            OP_J: begin
                dec_jump = 1'b1;
                dec_kill = 1'b1;
            end
            OP_JAL: begin
                dec_jump          = 1'b1;
                dec_word.dst      = '1;
                dec_word.regwrite = 1'b1;
                dec_word.memtoreg = 2'b10;
            end
            default: begin
                dec_illegal = 1'b1;
                dec_kill    = 1'b1;
            end
        endcase
    end

    ctrl_t ex_q, ex_d;
    ctrl_t mem_q, mem_d;
    ctrl_t wb_q, wb_d;

    logic id_active;
    logic hazard;
    logic stall;
    logic bubble;

    // The ID instruction is consumed on a rising edge when instr_valid_i=1 and stall_o=0;
    // while stall_o=1 the fetch side must hold PC and IF/ID so instr_i is re-presented.
    assign id_active = instr_valid_i & ~flush_i;
    assign hazard    = ex_q.memread & (ex_q.dst != '0)
                     & ((ex_q.dst == REG_W'(rs)) | (dec_uses_rt & (ex_q.dst == REG_W'(rt))))
                     & instr_valid_i;
    assign stall     = hazard & ~flush_i;
    assign bubble    = stall | flush_i | ~instr_valid_i | dec_kill;

    always_comb begin
        ex_d  = bubble ? '0 : dec_word;
        mem_d = ex_q;
        wb_d  = mem_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign id_jump_o     = id_active & dec_jump;
    assign id_jr_o       = id_active & dec_jr;
    assign illegal_o     = id_active & dec_illegal;
    assign stall_o       = stall;

    assign ex_aluop_o    = ex_q.aluop;
    assign ex_alusrc_o   = ex_q.alusrc;
    assign ex_memread_o  = ex_q.memread;
    assign ex_dst_o      = ex_q.dst;

    assign mem_read_o    = mem_q.memread;
    assign mem_write_o   = mem_q.memwrite;
    assign mem_branch_o  = mem_q.branch;
    assign mem_btype_o   = mem_q.btype;
    assign mem_dst_o     = mem_q.dst;

    assign wb_regwrite_o = wb_q.regwrite;
    assign wb_memtoreg_o = wb_q.memtoreg;
    assign wb_dst_o      = wb_q.dst;

    // Fields that later stages carry but never drive out (shamt, EX-only and MEM-only controls).
    logic unused_bits;
    assign unused_bits = ^{instr_i[10:6], mem_q.aluop, mem_q.alusrc, mem_q.regwrite,
                           mem_q.memtoreg, wb_q.aluop, wb_q.alusrc, wb_q.memread,
                           wb_q.memwrite, wb_q.branch, wb_q.btype, ex_q.memwrite,
                           ex_q.branch, ex_q.btype, ex_q.regwrite, ex_q.memtoreg};

endmodule

// File: doc/ctrl_pipe_decoder.md
# ctrl_pipe_decoder

Pipelined main-control decoder for the five-stage MIPS datapath. It decodes the ID-stage instruction into a control word and carries that word through the ID/EX, EX/MEM and MEM/WB registers, together with the resolved destination register. It detects load-use hazards and inserts bubbles for stalls and for branch/jump flushes. It replaces the single-cycle opcode decoder used in the single-cycle CPU.

## Interface
- ALUOP_W, 3: width of the ALU-op field. Encodings below are zero-extended to this width; minimum 2.
- REG_W, 5: register-address width. jal destination is all-ones, i.e. 31 at default.

Clock and reset are one clock, with an asynchronous, active-low reset.
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  asynchronous active-low reset
- instr_i  in  32  ID-stage instruction (op [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0])
- instr_valid_i  in  1  instr_i holds a real instruction
- flush_i  in  1  kill ID-stage instruction (branch taken or jump)
- id_jump_o  out  1  j/jal in ID (combinational)
- id_jr_o  out  1  jr in ID (combinational)
- illegal_o  out  1  undecodable valid opcode in ID (combinational)
- stall_o  out  1  load-use hazard: hold PC and IF/ID
- ex_aluop_o  out  ALUOP_W  EX ALU op
- ex_alusrc_o  out  1  EX ALU operand B = immediate
- ex_memread_o  out  1  EX instruction is a load
- ex_dst_o  out  REG_W  EX destination register
- mem_read_o, mem_write_o, mem_branch_o  out  1 each  MEM controls
- mem_btype_o  out  2  00 beq, 01 bne
- mem_dst_o  out  REG_W  MEM destination register
- wb_regwrite_o  out  1  WB write enable
- wb_memtoreg_o  out  2  00 ALU, 01 memory, 10 PC+4
- wb_dst_o  out  REG_W  WB destination register

## Operation
Decode table. Unlisted fields are 0; dst 0 means no write.
- R-type (op 000000, funct ≠ 001000): ALUOp 010, dst rd, RegWrite.
- jr (op 000000, funct 001000): id_jr_o; bubble into EX.
- addi 001000: ALUOp 000, ALUSrc, dst rt, RegWrite.
- slti 001010: ALUOp 011, ALUSrc, dst rt, RegWrite.
- lw 100011: ALUOp 000, ALUSrc, MemRead, dst rt, RegWrite, MemToReg 01.
- sw 101011: ALUOp 000, ALUSrc, MemWrite.
- beq 000100: ALUOp 001, Branch, BranchType 00.
- j 000010: id_jump_o; bubble.
- jal 000011: id_jump_o, dst all-ones, RegWrite, MemToReg 10.
- Any other opcode with instr_valid_i=1: illegal_o=1; bubble.

Hazard detection:
- An instruction uses rt if it is R-type, beq, bne or sw.
- hazard = ex_memread_o & (ex_dst_o≠0) & (ex_dst_o==rs | (uses rt & ex_dst_o==rt)) & instr_valid_i.
- stall_o = hazard & ~flush_i.

Stage advance:
- EX loads a bubble (all-zero control word, dst 0) if stall_o, flush_i, ~instr_valid_i, illegal, j or jr.
- Otherwise EX loads the decoded word.
- MEM←EX and WB←MEM every cycle unconditionally; stalls never freeze EX/MEM/WB.
- The ID outputs id_jump_o, id_jr_o and illegal_o are forced to 0 when instr_valid_i=0 or flush_i=1.

## Timing
- Reset: every registered output is 0 asynchronously while rst_i=0. Combinational outputs follow instr_i.
- Latency: a control word appears on ex_* 1 cycle after being presented in ID, on mem_* after 2 cycles, and on wb_* after 3 cycles.
- Load-use: stall_o asserts in the same cycle the dependent instruction is in ID. It deasserts the next cycle because the load has moved to MEM. Exactly one bubble is inserted.
- Simultaneous stall and flush: flush wins, stall_o=0, one bubble.
- A reset deasserted mid-stream restarts with an empty pipe. No stall is possible on the first cycle.
- Register 0 as a load destination never stalls.

## Configuration
- DECODE_BNE_EN defined: op 000101 decodes as bne with ALUOp 001, Branch, BranchType 01, and uses rt.
- DECODE_BNE_EN undefined: op 000101 is illegal. illegal_o=1 and a bubble is inserted.

## Test plan
- Reset: hold rst_i=0 and toggle the clock. All registered outputs must be 0. Release reset and present addi $2,$0,5 → at cycle 1 ex_aluop_o=000, ex_alusrc_o=1, ex_dst_o=2; at cycle 3 wb_regwrite_o=1, wb_dst_o=2.
- Load-use: lw $3,0($1) followed by add $4,$3,$5 → stall_o=1 for exactly one cycle, ex_* all 0 the next cycle, then the add appears in EX with ex_dst_o=4.
- Flush with hazard: the same lw/add pair with flush_i=1 on the add cycle → stall_o=0 and a bubble enters EX.
- jal: present jal → id_jump_o=1 in that cycle, then 3 cycles later wb_memtoreg_o=10 and wb_dst_o=31.
- Opcode 000101: with DECODE_BNE_EN → mem_branch_o=1 and mem_btype_o=01 after 2 cycles. Without the macro → illegal_o=1 and all downstream controls 0.
- Invalid instruction: instr_valid_i=0 carrying an lw encoding → stall_o=0, illegal_o=0, and a bubble propagates to WB.
